// File: rtl/sigmoid_pkg.sv
// Shared definitions for the sigmoid lookup table: default sizes, loader state
// encoding and the signed-x to table-address mapping.
package sigmoid_pkg;

    localparam int unsigned IN_WIDTH   = 10;
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned DEPTH      = 2 ** IN_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Offset-binary map: flip the sign bit of an width-bit two's-complement x,
    // so the most negative x lands at address 0. Bits above width are cleared.
    function automatic logic [31:0] sig_addr(input logic [31:0] x, input int unsigned width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (x ^ (32'd1 << (width - 1))) & mask;
    endfunction

endpackage

// File: rtl/act_table_ram.sv
// Simple dual-port table RAM: one write port, one registered read port.
// Read-before-write on an address collision; storage itself is never reset.
module act_table_ram #(
    parameter int unsigned addrWidth = 10,
    parameter int unsigned dataWidth = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [addrWidth-1:0] waddr,
    input  logic [dataWidth-1:0] wdata,
    input  logic [addrWidth-1:0] raddr,
    output logic [dataWidth-1:0] rdata
);

    localparam int unsigned Depth = 2 ** addrWidth;

    logic [dataWidth-1:0] mem [Depth];
    logic [dataWidth-1:0] rdata_q;

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; sees the pre-write entry when waddr == raddr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sigmoid_table_loader.sv
// Run-time loader for the sigmoid table plus the neuron lookup port.
// Entries stream in ascending address order over valid/ready; lookups are
// served every cycle with one-cycle latency regardless of load state.
module sigmoid_table_loader
    import sigmoid_pkg::*;
#(
    parameter int unsigned inWidth   = IN_WIDTH,
    parameter int unsigned dataWidth = DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 wr_valid,
    input  logic [dataWidth-1:0] wr_data,
    output logic                 wr_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 table_valid,
    input  logic [inWidth-1:0]   x,
    output logic [dataWidth-1:0] out,
    output logic                 out_valid
);

    state_t               state_q, state_d;
    logic [inWidth-1:0]   wr_addr_q, wr_addr_d;
    logic                 table_valid_q, table_valid_d;
    logic                 done_q, done_d;
    logic                 out_valid_q;
    logic                 we;
    logic [inWidth-1:0]   rd_addr;

    assign rd_addr = inWidth'(sig_addr(32'(x), inWidth));

    // State, address counter and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_addr_q     <= '0;
            table_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            table_valid_q <= table_valid_d;
            done_q        <= done_d;
        end
    end

    // Next-state logic; abort outranks both start and an in-flight transfer.
    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        table_valid_d = table_valid_q;
        done_d        = 1'b0;
        we            = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d       = LOAD;
                    wr_addr_d     = '0;
                    table_valid_d = 1'b0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (wr_valid) begin
                    we        = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (wr_addr_q == {inWidth{1'b1}}) begin
                        state_d       = DONE;
                        done_d        = 1'b1;
                        table_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Lookup validity tracks table_valid, delayed to align with out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= table_valid_q;
        end
    end

    act_table_ram #(
        .addrWidth (inWidth),
        .dataWidth (dataWidth)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (wr_addr_q),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (out)
    );

    assign wr_ready    = (state_q == LOAD);
    assign busy        = (state_q == LOAD);
    assign done        = done_q;
    assign table_valid = table_valid_q;
    assign out_valid   = out_valid_q;

endmodule
